csr_trap_ctrl: RTL and testbench



---
 rtl/csr_trap_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl -- machine-mode trap sequencer.
//
// Sequences the interrupt-side write port of the M-mode CSR file:
//   trap (ecall / ebreak / enabled interrupt): mepc -> mcause -> mstatus,
//     then a one-cycle fetch redirect to mtvec.
//   mret: mstatus restore, then a one-cycle fetch redirect to mepc.
// The pipeline is stalled from the accept cycle until the redirect cycle.
// The ex-side CSR write port has priority, so any write state that collides
// with it is held and re-presented until the write goes through once.
//
// Optional build macro: CSR_TRAP_VECTORED_EN
//   defined   -> interrupts with mtvec[1:0]==2'b01 jump to base + 4*cause code
//   undefined -> mtvec[1:0] ignored, base address always used
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   inst_addr_i       PC of the instruction in ex
//   inst_valid_i      ex holds a real instruction
//   ecall_i/ebreak_i/mret_i  decoded in ex
//   irq_timer_i/irq_ext_i    level interrupt requests
//   global_int_en_i   mstatus.MIE
//   csr_mstatus_i/csr_mtvec_i/csr_mepc_i  live CSR values
//   int_rdata_i       interrupt-side read data (mie)
//   ex_csr_we_i       ex-side CSR write active this cycle
//   int_raddr_o       constant mie address
//   int_we_o/int_waddr_o/int_wdata_o  interrupt-side write port
//   stall_o           hold IF/ID/EX
//   jump_o/jump_addr_o  one-cycle fetch redirect
module csr_trap_ctrl #(
  parameter int unsigned           DATA_W       = 32,
  parameter logic [DATA_W-1:0]     CAUSE_ECALL  = 32'h0000000B,
  parameter logic [DATA_W-1:0]     CAUSE_EBREAK = 32'h00000003,
  parameter logic [DATA_W-1:0]     CAUSE_MTI    = 32'h80000007,
  parameter logic [DATA_W-1:0]     CAUSE_MEI    = 32'h8000000B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inst_addr_i,
  input  logic              inst_valid_i,
  input  logic              ecall_i,
  input  logic              ebreak_i,
  input  logic              mret_i,
  input  logic              irq_timer_i,
  input  logic              irq_ext_i,
  input  logic              global_int_en_i,
  input  logic [DATA_W-1:0] csr_mstatus_i,
  input  logic [DATA_W-1:0] csr_mtvec_i,
  input  logic [DATA_W-1:0] csr_mepc_i,
  input  logic [DATA_W-1:0] int_rdata_i,
  input  logic              ex_csr_we_i,
  output logic [DATA_W-1:0] int_raddr_o,
  output logic              int_we_o,
  output logic [DATA_W-1:0] int_waddr_o,
  output logic [DATA_W-1:0] int_wdata_o,
  output logic              stall_o,
  output logic              jump_o,
  output logic [DATA_W-1:0] jump_addr_o
);

  localparam logic [DATA_W-1:0] ADDR_MSTATUS = DATA_W'(12'h300);
  localparam logic [DATA_W-1:0] ADDR_MIE     = DATA_W'(12'h304);
  localparam logic [DATA_W-1:0] ADDR_MEPC    = DATA_W'(12'h341);
  localparam logic [DATA_W-1:0] ADDR_MCAUSE  = DATA_W'(12'h342);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    T_JUMP,
    R_MSTATUS,
    R_JUMP
  } state_t;

  state_t             state, state_nxt;
  logic [DATA_W-3:0]  epc;      // word-aligned PC; low bits are always written as 0
  logic [DATA_W-1:0]  cause;

  logic               req_ecall, req_ebreak, req_mret, req_mei, req_mti;
  logic               take_trap;
  logic [DATA_W-1:0]  take_cause;
  logic [DATA_W-1:0]  mstatus_trap, mstatus_mret;
  logic [DATA_W-1:0]  mtvec_base, trap_target;
  logic               unused_bits;

  assign int_raddr_o = ADDR_MIE;

  assign req_ecall  = inst_valid_i & ecall_i;
  assign req_ebreak = inst_valid_i & ebreak_i;
  assign req_mret   = inst_valid_i & mret_i;
  assign req_mei    = inst_valid_i & global_int_en_i & irq_ext_i   & int_rdata_i[11];
  assign req_mti    = inst_valid_i & global_int_en_i & irq_timer_i & int_rdata_i[7];

  assign unused_bits = ^{int_rdata_i[DATA_W-1:12], int_rdata_i[10:8],
                         int_rdata_i[6:0], csr_mtvec_i[1:0]};

  // mstatus images: trap entry saves MIE into MPIE and clears MIE;
  // mret restores MIE from MPIE and sets MPIE. MPP is always M-mode.
  always_comb begin
    mstatus_trap        = csr_mstatus_i;
    mstatus_trap[7]     = csr_mstatus_i[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;

    mstatus_mret        = csr_mstatus_i;
    mstatus_mret[3]     = csr_mstatus_i[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;
  end

  assign mtvec_base = {csr_mtvec_i[DATA_W-1:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
  always_comb begin
    trap_target = mtvec_base;
    if (csr_mtvec_i[1:0] == 2'b01 && cause[DATA_W-1])
      trap_target = mtvec_base + {cause[DATA_W-3:0], 2'b00};
  end
`else
  assign trap_target = mtvec_base;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      epc   <= '0;
      cause <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && take_trap) begin
        epc   <= inst_addr_i[DATA_W-1:2];
        cause <= take_cause;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    take_trap   = 1'b0;
    take_cause  = '0;
    int_we_o    = 1'b0;
    int_waddr_o = '0;
    int_wdata_o = '0;
    stall_o     = 1'b0;
    jump_o      = 1'b0;
    jump_addr_o = '0;

    unique case (state)
      IDLE: begin
        // rst gates the accept path so outputs stay quiet while in reset.
        if (rst) begin
          if (req_ecall) begin
            take_trap  = 1'b1;
            take_cause = CAUSE_ECALL;
          end else if (req_ebreak) begin
            take_trap  = 1'b1;
            take_cause = CAUSE_EBREAK;
          end else if (!req_mret && req_mei) begin
            take_trap  = 1'b1;
            take_cause = CAUSE_MEI;
          end else if (!req_mret && req_mti) begin
            take_trap  = 1'b1;
            take_cause = CAUSE_MTI;
          end
          if (take_trap) begin
            stall_o   = 1'b1;
            state_nxt = W_MEPC;
          end else if (req_mret) begin
            stall_o   = 1'b1;
            state_nxt = R_MSTATUS;
          end
        end
      end
      W_MEPC: begin
        stall_o     = 1'b1;
        int_we_o    = 1'b1;
        int_waddr_o = ADDR_MEPC;
        int_wdata_o = {epc, 2'b00};
        if (!ex_csr_we_i) state_nxt = W_MCAUSE;
      end
      W_MCAUSE: begin
        stall_o     = 1'b1;
        int_we_o    = 1'b1;
        int_waddr_o = ADDR_MCAUSE;
        int_wdata_o = cause;
        if (!ex_csr_we_i) state_nxt = W_MSTATUS;
      end
      W_MSTATUS: begin
        stall_o     = 1'b1;
        int_we_o    = 1'b1;
        int_waddr_o = ADDR_MSTATUS;
        int_wdata_o = mstatus_trap;
        if (!ex_csr_we_i) state_nxt = T_JUMP;
      end
      T_JUMP: begin
        stall_o     = 1'b1;
        jump_o      = 1'b1;
        jump_addr_o = trap_target;
        state_nxt   = IDLE;
      end
      R_MSTATUS: begin
        stall_o     = 1'b1;
        int_we_o    = 1'b1;
        int_waddr_o = ADDR_MSTATUS;
        int_wdata_o = mstatus_mret;
        if (!ex_csr_we_i) state_nxt = R_JUMP;
      end
      R_JUMP: begin
        stall_o     = 1'b1;
        jump_o      = 1'b1;
        jump_addr_o = csr_mepc_i;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl -- directed and randomized bench for csr_trap_ctrl.
// Expected CSR write lists and jump targets are derived per request from the
// architectural trap/mret rules; each write is checked on every cycle it is
// presented and must be retired exactly once.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic        inst_valid, ecall, ebreak, mret, irq_timer, irq_ext, gie;
  logic [31:0] mstatus, mtvec, mepc, mie;
  logic        ex_we;
  logic [31:0] int_raddr, int_waddr, int_wdata, jump_addr;
  logic        int_we, stall, jump;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csr_trap_ctrl #(.DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_addr_i     (inst_addr),
    .inst_valid_i    (inst_valid),
    .ecall_i         (ecall),
    .ebreak_i        (ebreak),
    .mret_i          (mret),
    .irq_timer_i     (irq_timer),
    .irq_ext_i       (irq_ext),
    .global_int_en_i (gie),
    .csr_mstatus_i   (mstatus),
    .csr_mtvec_i     (mtvec),
    .csr_mepc_i      (mepc),
    .int_rdata_i     (mie),
    .ex_csr_we_i     (ex_we),
    .int_raddr_o     (int_raddr),
    .int_we_o        (int_we),
    .int_waddr_o     (int_waddr),
    .int_wdata_o     (int_wdata),
    .stall_o         (stall),
    .jump_o          (jump),
    .jump_addr_o     (jump_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".we"},    {31'd0, int_we}, 32'd0);
    chk({tag, ".waddr"}, int_waddr, 32'd0);
    chk({tag, ".wdata"}, int_wdata, 32'd0);
    chk({tag, ".jump"},  {31'd0, jump}, 32'd0);
    chk({tag, ".jaddr"}, jump_addr, 32'd0);
  endtask

  // One request presented in an IDLE cycle, followed through to the end of
  // its sequence. Called at posedge+1; returns at posedge+1.
  task automatic do_req(input string tag, input logic valid, input logic [31:0] pc,
                        input bit e, input bit b, input bit m, input bit ti, input bit xi,
                        input bit ie, input logic [31:0] mie_v, input logic [31:0] ms,
                        input logic [31:0] tvec, input logic [31:0] epc_v,
                        input int hold_idx, input int hold_n, input bit rnd);
    int          kind;
    logic [31:0] cause, target;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    kind = 0; cause = 0; target = 0;
    if (valid) begin
      if (e)                              begin kind = 1; cause = 32'h0000000B; end
      else if (b)                         begin kind = 1; cause = 32'h00000003; end
      else if (m)                                kind = 2;
      else if (xi && ie && mie_v[11])     begin kind = 1; cause = 32'h8000000B; end
      else if (ti && ie && mie_v[7])      begin kind = 1; cause = 32'h80000007; end
    end
    if (kind == 1) begin
      wa.push_back(32'h341); wd.push_back(pc & ~32'h3);
      wa.push_back(32'h342); wd.push_back(cause);
      wa.push_back(32'h300);
      wd.push_back((ms & ~32'h88) | (((ms >> 3) & 32'h1) << 7) | 32'h1800);
      target = tvec & ~32'h3;
`ifdef CSR_TRAP_VECTORED_EN
      if (tvec[1:0] == 2'b01 && cause[31]) target = target + (cause & 32'h7FFFFFFF) * 4;
`endif
    end else if (kind == 2) begin
      wa.push_back(32'h300);
      wd.push_back((ms & ~32'h8) | (((ms >> 7) & 32'h1) << 3) | 32'h80 | 32'h1800);
      target = epc_v;
    end

    inst_valid = valid; inst_addr = pc;
    ecall = e; ebreak = b; mret = m; irq_timer = ti; irq_ext = xi; gie = ie;
    mie = mie_v; mstatus = ms; mtvec = tvec; mepc = epc_v;
    ex_we = 1'($urandom_range(0, 1));
    #1;
    chk({tag, ".accept_stall"}, {31'd0, stall}, (kind != 0) ? 32'd1 : 32'd0);
    chk_quiet({tag, ".accept"});
    @(posedge clk); #1;
    ecall = 0; ebreak = 0; mret = 0; irq_timer = 0; irq_ext = 0;
    inst_valid = 1'($urandom_range(0, 1));

    if (kind != 0) begin
      for (int w = 0; w < wa.size(); w++) begin
        int holds;
        holds = (w == hold_idx) ? hold_n : (rnd ? int'($urandom_range(0, 2)) : 0);
        for (int h = 0; h <= holds; h++) begin
          ex_we = (h < holds);
          #1;
          chk($sformatf("%s.w%0d.we", tag, w),    {31'd0, int_we}, 32'd1);
          chk($sformatf("%s.w%0d.addr", tag, w),  int_waddr, wa[w]);
          chk($sformatf("%s.w%0d.data", tag, w),  int_wdata, wd[w]);
          chk($sformatf("%s.w%0d.stall", tag, w), {31'd0, stall}, 32'd1);
          chk($sformatf("%s.w%0d.jump", tag, w),  {31'd0, jump}, 32'd0);
          @(posedge clk); #1;
        end
      end
      ex_we = 1'($urandom_range(0, 1));
      #1;
      chk({tag, ".jump"},       {31'd0, jump}, 32'd1);
      chk({tag, ".jump_addr"},  jump_addr, target);
      chk({tag, ".jump_stall"}, {31'd0, stall}, 32'd1);
      chk({tag, ".jump_we"},    {31'd0, int_we}, 32'd0);
      @(posedge clk); #1;
      ex_we = 0;
      #1;
      chk({tag, ".after_stall"}, {31'd0, stall}, 32'd0);
      chk_quiet({tag, ".after"});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; inst_addr = 0; inst_valid = 0; ecall = 0; ebreak = 0; mret = 0;
    irq_timer = 0; irq_ext = 0; gie = 0; mstatus = 0; mtvec = 0; mepc = 0; mie = 0; ex_we = 0;
    #2;
    chk("reset.stall", {31'd0, stall}, 32'd0);
    chk("reset.raddr", int_raddr, 32'h304);
    chk_quiet("reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    do_req("ecall", 1, 32'h120, 1, 0, 0, 0, 0, 1, 32'h0, 32'h88, 32'h400, 32'h0, -1, 0, 0);
    do_req("mei", 1, 32'h200, 0, 0, 0, 0, 1, 1, 32'h800, 32'h88, 32'h400, 32'h0, -1, 0, 0);
    do_req("mei_gie0", 1, 32'h200, 0, 0, 0, 0, 1, 0, 32'h800, 32'h80, 32'h400, 32'h0, -1, 0, 0);
    do_req("mei_mie0", 1, 32'h200, 0, 0, 0, 0, 1, 1, 32'h0, 32'h88, 32'h400, 32'h0, -1, 0, 0);
    do_req("invalid", 0, 32'h204, 1, 0, 0, 0, 1, 1, 32'h880, 32'h88, 32'h400, 32'h0, -1, 0, 0);
    do_req("both_irq", 1, 32'h300, 0, 0, 0, 1, 1, 1, 32'h880, 32'h88, 32'h400, 32'h0, -1, 0, 0);
    do_req("mret", 1, 32'h304, 0, 0, 1, 1, 1, 0, 32'h880, 32'h1880, 32'h400, 32'h124, -1, 0, 0);
    do_req("mti", 1, 32'h124, 0, 0, 0, 1, 0, 1, 32'h880, 32'h1888, 32'h401, 32'h0, -1, 0, 0);
    do_req("prio_ebreak", 1, 32'h13A, 0, 1, 1, 1, 1, 1, 32'h880, 32'h8, 32'h400, 32'h0, -1, 0, 0);
    do_req("prio_mret", 1, 32'h13C, 0, 0, 1, 1, 1, 1, 32'h880, 32'h80, 32'h400, 32'h88, -1, 0, 0);
    do_req("contend", 1, 32'h128, 1, 0, 0, 0, 0, 1, 32'h0, 32'h88, 32'h400, 32'h0, 1, 2, 0);

    // Reset while the mcause write is being presented.
    inst_valid = 1; inst_addr = 32'h500; ecall = 1; mstatus = 32'h88; mtvec = 32'h400; ex_we = 0;
    @(posedge clk); #1;
    ecall = 0;
    @(posedge clk); #1;
    chk("rst_mid.pre_addr", int_waddr, 32'h342);
    rst = 1'b0;
    #1;
    chk("rst_mid.stall", {31'd0, stall}, 32'd0);
    chk("rst_mid.raddr", int_raddr, 32'h304);
    chk_quiet("rst_mid");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    #1;
    chk("rst_mid.idle_stall", {31'd0, stall}, 32'd0);
    chk_quiet("rst_mid.idle");
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      do_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0), $urandom,
             $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
             $urandom, $urandom, $urandom, $urandom, -1, 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
